// File: rtl/instr_prog_loader.sv
// Double-buffered instruction program loader: streams words into the shadow bank,
// then swaps banks on the first sample boundary after a commit.
module instr_prog_loader #(
  parameter  int n_blocks = 256,
  localparam int AW       = $clog2(n_blocks)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_tick,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  input  logic          load_commit,
  output logic          mem_we,
  output logic          mem_wbank,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          active_bank,
  output logic [AW-1:0] n_blocks_running,
  output logic [AW-1:0] last_block,
  output logic          pipe_enable,
  output logic          fetch_restart,
  output logic          commit_pending,
  output logic          commit_done,
  output logic          overflow_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_TICK,
    SWAP
  } state_e;

  // One slot is reserved, so the longest program is n_blocks-1 words.
  localparam logic [AW-1:0] MAX_PTR = AW'(n_blocks - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          overflow_q, overflow_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_wbank_q, mem_wbank_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          active_bank_q, active_bank_d;
  logic [AW-1:0] n_run_q, n_run_d;
  logic [AW-1:0] last_block_q, last_block_d;
  logic          done_q, done_d;
  logic          can_accept;

  assign can_accept = (wr_ptr_q < MAX_PTR);

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    overflow_d     = overflow_q;
    mem_we_d       = 1'b0;
    mem_wbank_d    = mem_wbank_q;
    mem_waddr_d    = mem_waddr_q;
    mem_wdata_d    = mem_wdata_q;
    active_bank_d  = active_bank_q;
    n_run_d        = n_run_q;
    last_block_d   = last_block_q;
    done_d         = 1'b0;
    load_ready     = 1'b0;
    pipe_enable    = 1'b1;
    commit_pending = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A commit here has no program behind it, so it is dropped.
        if (load_start) begin
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        load_ready = can_accept;
        if (load_start) begin
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else begin
          if (load_valid) begin
            if (can_accept) begin
              mem_we_d    = 1'b1;
              mem_wbank_d = ~active_bank_q;
              mem_waddr_d = wr_ptr_q;
              mem_wdata_d = load_data;
              wr_ptr_d    = wr_ptr_q + AW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
          // A tick in this same cycle is deliberately not seen: only WAIT_TICK reacts.
          if (load_commit) state_d = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        commit_pending = 1'b1;
        if (sample_tick) state_d = SWAP;
      end

      SWAP: begin
        commit_pending = 1'b1;
        pipe_enable    = 1'b0;
        active_bank_d  = ~active_bank_q;
        n_run_d        = wr_ptr_q;
        last_block_d   = (wr_ptr_q == '0) ? '0 : wr_ptr_q - AW'(1);
        done_d         = 1'b1;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and wins over every input; all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wbank_q   <= 1'b1;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      active_bank_q <= 1'b0;
      n_run_q       <= '0;
      last_block_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      overflow_q    <= overflow_d;
      mem_we_q      <= mem_we_d;
      mem_wbank_q   <= mem_wbank_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      active_bank_q <= active_bank_d;
      n_run_q       <= n_run_d;
      last_block_q  <= last_block_d;
      done_q        <= done_d;
    end
  end

  assign mem_we           = mem_we_q;
  assign mem_wbank        = mem_wbank_q;
  assign mem_waddr        = mem_waddr_q;
  assign mem_wdata        = mem_wdata_q;
  assign active_bank      = active_bank_q;
  assign n_blocks_running = n_run_q;
  assign last_block       = last_block_q;
  assign commit_done      = done_q;
  assign fetch_restart    = done_q;
  assign overflow_err     = overflow_q;

endmodule

// File: tb/tb_instr_prog_loader.sv
// Directed bench for instr_prog_loader with an 8-slot bank (7-word maximum program).
module tb_instr_prog_loader;

  localparam int NB = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          load_start;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_ready;
  logic          load_commit;
  logic          mem_we;
  logic          mem_wbank;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          active_bank;
  logic [AW-1:0] n_blocks_running;
  logic [AW-1:0] last_block;
  logic          pipe_enable;
  logic          fetch_restart;
  logic          commit_pending;
  logic          commit_done;
  logic          overflow_err;

  int n_checks = 0;
  int n_pass   = 0;

  instr_prog_loader #(.n_blocks(NB)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_tick      (sample_tick),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_ready       (load_ready),
    .load_commit      (load_commit),
    .mem_we           (mem_we),
    .mem_wbank        (mem_wbank),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata),
    .active_bank      (active_bank),
    .n_blocks_running (n_blocks_running),
    .last_block       (last_block),
    .pipe_enable      (pipe_enable),
    .fetch_restart    (fetch_restart),
    .commit_pending   (commit_pending),
    .commit_done      (commit_done),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sample_tick = 1'b0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    load_commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    n_checks++;
    if ({load_ready, mem_we, mem_wbank, active_bank, pipe_enable, fetch_restart,
         commit_pending, commit_done, overflow_err} !== 9'b001010000)
      $display("FAIL reset_flags got %b exp %b", {load_ready, mem_we, mem_wbank, active_bank,
               pipe_enable, fetch_restart, commit_pending, commit_done, overflow_err}, 9'b001010000);
    else n_pass++;
    n_checks++;
    if ({mem_waddr, mem_wdata, n_blocks_running, last_block} !== 41'd0)
      $display("FAIL reset_fields got %h exp 0", {mem_waddr, mem_wdata, n_blocks_running, last_block});
    else n_pass++;
    reset = 1'b0;
  endtask

  // Three-word program, commit, tick five cycles later.
  task automatic test_basic_program();
    load_start = 1'b1; step(); load_start = 1'b0;
    n_checks++;
    if ({load_ready, commit_pending} !== 2'b10)
      $display("FAIL basic_load_ready got %b exp 10", {load_ready, commit_pending});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(10 + i);
      step();
      n_checks++;
      if ({mem_we, mem_wbank, mem_waddr, mem_wdata} !== {1'b1, 1'b1, AW'(i), 32'(10 + i)})
        $display("FAIL basic_write%0d got we=%b bank=%b addr=%0d data=%h exp we=1 bank=1 addr=%0d data=%h",
                 i, mem_we, mem_wbank, mem_waddr, mem_wdata, i, 32'(10 + i));
      else n_pass++;
    end
    load_valid = 1'b0; load_commit = 1'b1; step(); load_commit = 1'b0;
    n_checks++;
    if ({mem_we, load_ready, commit_pending, pipe_enable} !== 4'b0011)
      $display("FAIL basic_commit got %b exp 0011", {mem_we, load_ready, commit_pending, pipe_enable});
    else n_pass++;
    repeat (4) step();
    n_checks++;
    if ({commit_pending, active_bank, commit_done, pipe_enable} !== 4'b1001)
      $display("FAIL basic_waiting got %b exp 1001", {commit_pending, active_bank, commit_done, pipe_enable});
    else n_pass++;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    n_checks++;
    if ({pipe_enable, commit_pending, active_bank, commit_done} !== 4'b0100)
      $display("FAIL basic_swap got %b exp 0100", {pipe_enable, commit_pending, active_bank, commit_done});
    else n_pass++;
    step();
    n_checks++;
    if ({active_bank, n_blocks_running, last_block, commit_done, fetch_restart, pipe_enable, commit_pending}
        !== {1'b1, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL basic_config got bank=%b run=%0d last=%0d done=%b restart=%b pe=%b pend=%b exp 1 3 2 1 1 1 0",
               active_bank, n_blocks_running, last_block, commit_done, fetch_restart, pipe_enable, commit_pending);
    else n_pass++;
    step();
    n_checks++;
    if ({commit_done, fetch_restart} !== 2'b00)
      $display("FAIL basic_pulse_end got %b exp 00", {commit_done, fetch_restart});
    else n_pass++;
  endtask

  // Word, commit and tick in one cycle: the tick must not trigger the swap.
  task automatic test_tick_coincide();
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'h55; load_commit = 1'b1; sample_tick = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if ({mem_we, mem_wbank, mem_waddr, mem_wdata} !== {1'b1, 1'b0, 3'd0, 32'h55})
      $display("FAIL coincide_write got we=%b bank=%b addr=%0d data=%h exp 1 0 0 55",
               mem_we, mem_wbank, mem_waddr, mem_wdata);
    else n_pass++;
    n_checks++;
    if ({commit_pending, pipe_enable} !== 2'b11)
      $display("FAIL coincide_no_swap got %b exp 11", {commit_pending, pipe_enable});
    else n_pass++;
    step();
    n_checks++;
    if ({commit_pending, pipe_enable, commit_done} !== 3'b110)
      $display("FAIL coincide_still_wait got %b exp 110", {commit_pending, pipe_enable, commit_done});
    else n_pass++;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    n_checks++;
    if (pipe_enable !== 1'b0)
      $display("FAIL coincide_swap got pe=%b exp 0", pipe_enable);
    else n_pass++;
    step();
    n_checks++;
    if ({active_bank, n_blocks_running, last_block, commit_done} !== {1'b0, 3'd1, 3'd0, 1'b1})
      $display("FAIL coincide_config got bank=%b run=%0d last=%0d done=%b exp 0 1 0 1",
               active_bank, n_blocks_running, last_block, commit_done);
    else n_pass++;
  endtask

  // Nine words into an 8-slot bank: seven land, the rest flag overflow.
  task automatic test_overflow();
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (load_ready !== (i < 7))
        $display("FAIL ovf_ready%0d got %b exp %b", i, load_ready, (i < 7));
      else n_pass++;
      load_valid = 1'b1;
      load_data  = 32'(256 + i);
      step();
      n_checks++;
      if (mem_we !== (i < 7))
        $display("FAIL ovf_we%0d got %b exp %b", i, mem_we, (i < 7));
      else n_pass++;
      if (i < 7) begin
        n_checks++;
        if ({mem_wbank, mem_waddr, mem_wdata} !== {1'b1, AW'(i), 32'(256 + i)})
          $display("FAIL ovf_addr%0d got bank=%b addr=%0d data=%h exp 1 %0d %h",
                   i, mem_wbank, mem_waddr, mem_wdata, i, 32'(256 + i));
        else n_pass++;
      end
    end
    load_valid = 1'b0;
    n_checks++;
    if ({load_ready, overflow_err} !== 2'b01)
      $display("FAIL ovf_flag got %b exp 01", {load_ready, overflow_err});
    else n_pass++;
    load_commit = 1'b1; step(); load_commit = 1'b0;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    step();
    n_checks++;
    if ({active_bank, n_blocks_running, last_block, overflow_err} !== {1'b1, 3'd7, 3'd6, 1'b1})
      $display("FAIL ovf_config got bank=%b run=%0d last=%0d ovf=%b exp 1 7 6 1",
               active_bank, n_blocks_running, last_block, overflow_err);
    else n_pass++;
  endtask

  // Empty program: commit straight after load_start.
  task automatic test_empty_program();
    load_start = 1'b1; step(); load_start = 1'b0;
    n_checks++;
    if ({overflow_err, load_ready} !== 2'b01)
      $display("FAIL empty_start got %b exp 01", {overflow_err, load_ready});
    else n_pass++;
    load_commit = 1'b1; step(); load_commit = 1'b0;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    step();
    n_checks++;
    if ({active_bank, n_blocks_running, last_block, commit_done} !== {1'b0, 3'd0, 3'd0, 1'b1})
      $display("FAIL empty_config got bank=%b run=%0d last=%0d done=%b exp 0 0 0 1",
               active_bank, n_blocks_running, last_block, commit_done);
    else n_pass++;
  endtask

  // Reset while a commit is pending, with competing inputs in the reset cycle.
  task automatic test_reset_mid_commit();
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'h77; step(); load_valid = 1'b0;
    load_commit = 1'b1; step(); load_commit = 1'b0;
    n_checks++;
    if (commit_pending !== 1'b1)
      $display("FAIL rmid_pending got %b exp 1", commit_pending);
    else n_pass++;
    reset = 1'b1; load_start = 1'b1; sample_tick = 1'b1;
    step();
    reset = 1'b0; clear_inputs();
    n_checks++;
    if ({load_ready, mem_we, mem_wbank, active_bank, pipe_enable, fetch_restart,
         commit_pending, commit_done, overflow_err} !== 9'b001010000)
      $display("FAIL rmid_flags got %b exp %b", {load_ready, mem_we, mem_wbank, active_bank,
               pipe_enable, fetch_restart, commit_pending, commit_done, overflow_err}, 9'b001010000);
    else n_pass++;
    n_checks++;
    if ({mem_waddr, mem_wdata, n_blocks_running, last_block} !== 41'd0)
      $display("FAIL rmid_fields got %h exp 0", {mem_waddr, mem_wdata, n_blocks_running, last_block});
    else n_pass++;
    sample_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({pipe_enable, commit_done, active_bank, commit_pending} !== 4'b1000)
        $display("FAIL rmid_no_swap%0d got %b exp 1000", i, {pipe_enable, commit_done, active_bank, commit_pending});
      else n_pass++;
    end
    sample_tick = 1'b0;
  endtask

  // Two programs back to back: banks alternate 1 then 0.
  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      load_start = 1'b1; step(); load_start = 1'b0;
      load_valid = 1'b1; load_data = 32'(512 + p); step(); load_valid = 1'b0;
      n_checks++;
      if ({mem_we, mem_wbank} !== {1'b1, (p == 0)})
        $display("FAIL b2b_bank%0d got we=%b bank=%b exp 1 %b", p, mem_we, mem_wbank, (p == 0));
      else n_pass++;
      load_commit = 1'b1; step(); load_commit = 1'b0;
      sample_tick = 1'b1; step(); sample_tick = 1'b0;
      step();
      n_checks++;
      if ({active_bank, n_blocks_running, commit_done} !== {(p == 0), 3'd1, 1'b1})
        $display("FAIL b2b_active%0d got bank=%b run=%0d done=%b exp %b 1 1",
                 p, active_bank, n_blocks_running, commit_done, (p == 0));
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_program();
    test_tick_coincide();
    test_overflow();
    test_empty_program();
    test_reset_mid_commit();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_prog_loader.md
INSTR_PROG_LOADER -- requirements
Module: instr_prog_loader

Interface
REQ-001 SHALL have parameter n_blocks, default 256, meaning instruction slots per bank.
REQ-002 SHALL have parameter AW, fixed at $clog2(n_blocks), meaning block address width; it is not overridable.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle pulse marking a sample boundary.
REQ-006 SHALL have port load_start  input  1  pulse; begin a new program into the shadow bank.
REQ-007 SHALL have ports load_valid input 1, load_data input 32, load_ready output 1, forming the instruction-word stream handshake.
REQ-008 SHALL have port load_commit  input  1  pulse; request a swap to the shadow bank.
REQ-009 SHALL have ports mem_we output 1, mem_wbank output 1, mem_waddr output AW, mem_wdata output 32, forming the instruction-memory write port.
REQ-010 SHALL have ports active_bank output 1, n_blocks_running output AW, last_block output AW, forming the fetch-side configuration.
REQ-011 SHALL have port pipe_enable  output  1  enable to the fetch/decode pipeline.
REQ-012 SHALL have port fetch_restart  output  1  pulse; the fetch address returns to 0.
REQ-013 SHALL have ports commit_pending output 1, commit_done output 1, overflow_err output 1, forming the status outputs.

Function
REQ-014 SHALL implement the states IDLE, LOAD, WAIT_TICK and SWAP.
REQ-015 SHALL define the shadow bank as the bank other than active_bank.
REQ-016 SHALL, in IDLE on load_start, clear wr_ptr to 0 and go to LOAD.
REQ-017 SHALL, in IDLE, ignore load_commit when no load has occurred since the last commit or reset.
REQ-018 SHALL, in LOAD, drive load_ready = (wr_ptr < n_blocks-1).
REQ-019 SHALL, in LOAD on each cycle with load_valid && load_ready, register a write with mem_we=1, mem_wbank=shadow, mem_waddr=wr_ptr, mem_wdata=load_data, all valid the next cycle (1-cycle write latency), and increment wr_ptr.
REQ-020 SHALL drive mem_we to 0 in every cycle where REQ-019 does not apply.
REQ-021 SHALL cap wr_ptr at n_blocks-1, the maximum program length.
REQ-022 SHALL, on load_valid while wr_ptr == n_blocks-1, set overflow_err, discard the word, and leave wr_ptr unchanged.
REQ-023 SHALL hold overflow_err sticky until the next load_start or reset.
REQ-024 SHALL, when load_valid && load_ready and load_commit occur in the same cycle, accept the word and then go to WAIT_TICK.
REQ-025 SHALL, in LOAD on load_start, restart at wr_ptr=0 and keep previously written words as don't-care.
REQ-026 SHALL hold load_ready at 0 in WAIT_TICK and SWAP.
REQ-027 SHALL ignore load_start in WAIT_TICK and SWAP.
REQ-028 SHALL drive commit_pending to 1 exactly while in WAIT_TICK or SWAP.
REQ-029 SHALL, in WAIT_TICK, go to SWAP on the first sample_tick strictly after the cycle in which load_commit was accepted.
REQ-030 SHALL ignore a tick that coincides with the commit cycle.
REQ-031 SHALL make SWAP exactly 1 cycle with pipe_enable=0.
REQ-032 SHALL, at the end of SWAP, toggle active_bank, set n_blocks_running=wr_ptr, set last_block = (wr_ptr==0) ? 0 : wr_ptr-1, and go to IDLE.
REQ-033 SHALL pulse commit_done and fetch_restart for exactly the 1 cycle after SWAP, concurrent with the new configuration.
REQ-034 SHALL, on a commit with wr_ptr==0, give n_blocks_running=0 (pipeline halted) and last_block=0.
REQ-035 SHALL drive pipe_enable to 1 in all states other than SWAP.
REQ-036 SHALL ignore sample_tick outside WAIT_TICK.

Reset
REQ-037 SHALL give the following values on reset: state=IDLE, wr_ptr=0, load_ready=0, mem_we=0, mem_wbank=1, mem_waddr=0, mem_wdata=0, active_bank=0, n_blocks_running=0, last_block=0, pipe_enable=1, fetch_restart=0, commit_pending=0, commit_done=0, overflow_err=0.
REQ-038 SHALL abort any in-progress load or pending commit on reset mid-operation, with no swap.
REQ-039 SHALL take reset priority over every other input in the same cycle.

Verification
REQ-040 SHALL pass this scenario: load_start, 3 words 0xA,0xB,0xC, load_commit, tick 5 cycles later -> bank1 addr0..2 written, a SWAP cycle with pipe_enable=0, then active_bank=1, n_blocks_running=3, last_block=2, and a 1-cycle commit_done/fetch_restart pulse.
REQ-041 SHALL pass this scenario: load_commit in the same cycle as sample_tick -> no swap on that tick, swap on the next tick only.
REQ-042 SHALL pass this scenario: n_blocks=8, stream 9 words -> 7 writes (addr 0..6), load_ready=0 after the 7th write, overflow_err=1, and n_blocks_running=7 after commit.
REQ-043 SHALL pass this scenario: load_start then immediate commit (0 words) -> after tick, n_blocks_running=0, last_block=0, and bank toggled.
REQ-044 SHALL pass this scenario: reset asserted in WAIT_TICK -> all outputs at reset values, and later ticks cause no swap.
REQ-045 SHALL pass this scenario: two back-to-back programs -> second writes target bank0 and active_bank returns to 0.
